// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: round-robin grant among head-flit requesters,
// held until the owner's tail flit crosses the crossbar.
module output_port_arbiter #(
   parameter int NUM_IN = 5,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_IN-1:0]   req,
   input  logic [NUM_IN-1:0]   flit_valid,
   input  logic [2*NUM_IN-1:0] flit_type,
   input  logic                out_ready,
   output logic [NUM_IN-1:0]   grant,
   output logic [2:0]          xbar_sel,
   output logic                out_valid,
   output logic                busy,
   output logic [CNT_W-1:0]    pkt_count,
   output logic                err
);

   localparam logic [2:0] SEL_IDLE = 3'd7;
   localparam logic [1:0] TYPE_HEAD = 2'b10;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } state_e;

   state_e            state_q, state_d;
   logic [NUM_IN-1:0] grant_q, grant_d;
   logic [2:0]        sel_q, sel_d;
   logic [2:0]        ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              moved_q, moved_d;

   logic [NUM_IN-1:0] cand;
   logic [2:0]        scan_idx;
   logic [2:0]        win_idx;
   logic              win_found;
   logic              owner_fv;
   logic [1:0]        owner_type;
   logic              xfer;
   logic              pkt_end;
   logic              bad_head;

   function automatic logic [2:0] wrap_inc(input logic [2:0] v);
      return (v == 3'(NUM_IN - 1)) ? 3'd0 : v + 3'd1;
   endfunction

   // Only head (10) or head+tail (11) flits may open a packet.
   always_comb begin
      cand = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         cand[i] = req[i] & flit_valid[i] & flit_type[2*i+1];
      end
   end

   // Scan from ptr upward with wrap; the first candidate found wins.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so no path leaves it unassigned and infers a latch.
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = ptr_q;
      for (int k = 0; k < NUM_IN; k++) begin
         if (!win_found && cand[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
         scan_idx = wrap_inc(scan_idx);
      end
   end

   always_comb begin
      owner_fv   = |(flit_valid & grant_q);
      owner_type = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant_q[i]) begin
            owner_type = owner_type | flit_type[2*i +: 2];
         end
      end
   end

   assign xfer     = (state_q == ST_LOCKED) & owner_fv & out_ready;
   assign pkt_end  = xfer & owner_type[0];
   // A fresh head after the owner has already moved a flit means a lost tail.
   assign bad_head = (state_q == ST_LOCKED) & owner_fv & moved_q &
                     (owner_type == TYPE_HEAD);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      moved_d = moved_q;
      unique case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d          = ST_LOCKED;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               sel_d            = win_idx;
               moved_d          = 1'b0;
            end
         end
         ST_LOCKED: begin
            if (xfer) begin
               moved_d = 1'b1;
            end
            if (bad_head) begin
               err_d = 1'b1;
            end
            if (pkt_end) begin
               state_d = ST_IDLE;
               grant_d = '0;
               sel_d   = SEL_IDLE;
               ptr_d   = wrap_inc(sel_q);
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         sel_q   <= SEL_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         moved_q <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop samples the pre-edge values.
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         moved_q <= moved_d;
      end
   end

   assign grant     = grant_q;
   assign xbar_sel  = sel_q;
   assign out_valid = xfer;
   assign busy      = (state_q == ST_LOCKED);
   assign pkt_count = cnt_q;
   assign err       = err_q;

   a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
   a_busy_matches  : assert property (@(posedge clk) disable iff (rst) busy == (|grant_q));

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed self-checking bench for output_port_arbiter; inputs change on the
// falling edge and outputs are sampled 1 time unit later.
module tb_output_port_arbiter;

   logic        clk;
   logic        rst;
   logic [4:0]  req;
   logic [4:0]  fv;
   logic [9:0]  ftype;
   logic        out_ready;
   logic [4:0]  grant;
   logic [2:0]  xbar_sel;
   logic        out_valid;
   logic        busy;
   logic [15:0] pkt_count;
   logic        err;

   int checks;
   int failures;
   logic [10:0] exp;

   output_port_arbiter #(.NUM_IN(5), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .flit_valid (fv),
      .flit_type  (ftype),
      .out_ready  (out_ready),
      .grant      (grant),
      .xbar_sel   (xbar_sel),
      .out_valid  (out_valid),
      .busy       (busy),
      .pkt_count  (pkt_count),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   // Snapshot order: grant, xbar_sel, out_valid, busy, err.
   function automatic logic [10:0] snap();
      return {grant, xbar_sel, out_valid, busy, err};
   endfunction

   function automatic logic [10:0] mk(input logic [4:0] g, input logic [2:0] s,
                                      input logic ov, input logic b, input logic e);
      return {g, s, ov, b, e};
   endfunction

   task automatic drive(input int i, input logic r, input logic v, input logic [1:0] t);
      req[i]          = r;
      fv[i]           = v;
      ftype[2*i +: 2] = t;
   endtask

   task automatic clear_all();
      req   = '0;
      fv    = '0;
      ftype = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_all();
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      exp = mk(5'b00000, 3'd7, 1'b0, 1'b0, 1'b0);
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL reset_state got=%b exp=%b", snap(), exp); end
      checks++;
      if (pkt_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", pkt_count); end
      rst = 1'b0;
   endtask

   task automatic test_single_packet();
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 2'b10);
      out_ready = 1'b1;
      #1;
      exp = mk(5'b00000, 3'd7, 1'b0, 1'b0, 1'b0);
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL t1_req_cycle got=%b exp=%b", snap(), exp); end
      @(negedge clk); #1;
      exp = mk(5'b00001, 3'd0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL t1_head got=%b exp=%b", snap(), exp); end
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         drive(0, 1'b0, 1'b1, 2'b00);
         #1;
         checks++;
         if (snap() !== exp) begin failures++; $display("FAIL t1_body%0d got=%b exp=%b", b, snap(), exp); end
      end
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 2'b01);
      #1;
      checks++;
      if (snap() !== exp || pkt_count !== 16'd0) begin
         failures++; $display("FAIL t1_tail got=%b cnt=%0d exp=%b cnt=0", snap(), pkt_count, exp);
      end
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 2'b00);
      #1;
      exp = mk(5'b00000, 3'd7, 1'b0, 1'b0, 1'b0);
      checks++;
      if (snap() !== exp || pkt_count !== 16'd1) begin
         failures++; $display("FAIL t1_release got=%b cnt=%0d exp=%b cnt=1", snap(), pkt_count, exp);
      end
      // With ptr now at E, E must beat a simultaneous L request.
      drive(0, 1'b1, 1'b1, 2'b11);
      drive(1, 1'b1, 1'b1, 2'b11);
      @(negedge clk); #1;
      exp = mk(5'b00010, 3'd1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL t1_ptr_after_l got=%b exp=%b", snap(), exp); end
      @(negedge clk);
      clear_all();
      #1;
      exp = mk(5'b00000, 3'd7, 1'b0, 1'b0, 1'b0);
      checks++;
      if (snap() !== exp || pkt_count !== 16'd2) begin
         failures++; $display("FAIL t1_e_single got=%b cnt=%0d exp=%b cnt=2", snap(), pkt_count, exp);
      end
   endtask

   task automatic test_round_robin();
      test_reset();
      @(negedge clk);
      for (int i = 0; i < 5; i++) drive(i, 1'b1, 1'b1, 2'b11);
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         exp = mk(5'b00001 << (k % 5), 3'(k % 5), 1'b1, 1'b1, 1'b0);
         checks++;
         if (snap() !== exp || pkt_count !== 16'(k)) begin
            failures++; $display("FAIL t2_grant%0d got=%b cnt=%0d exp=%b cnt=%0d", k, snap(), pkt_count, exp, k);
         end
         @(negedge clk); #1;
         exp = mk(5'b00000, 3'd7, 1'b0, 1'b0, 1'b0);
         checks++;
         if (snap() !== exp || pkt_count !== 16'(k + 1)) begin
            failures++; $display("FAIL t2_idle%0d got=%b cnt=%0d exp=%b cnt=%0d", k, snap(), pkt_count, exp, k + 1);
         end
      end
      clear_all();
   endtask

   task automatic test_stall();
      test_reset();
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 2'b10);
      drive(2, 1'b1, 1'b1, 2'b11);
      out_ready = 1'b1;
      @(negedge clk); #1;
      exp = mk(5'b00010, 3'd1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL t3_head got=%b exp=%b", snap(), exp); end
      @(negedge clk);
      drive(1, 1'b0, 1'b1, 2'b00);
      out_ready = 1'b0;
      exp = mk(5'b00010, 3'd1, 1'b0, 1'b1, 1'b0);
      for (int s = 0; s < 5; s++) begin
         if (s > 0) @(negedge clk);
         #1;
         checks++;
         if (snap() !== exp) begin failures++; $display("FAIL t3_stall%0d got=%b exp=%b", s, snap(), exp); end
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      exp = mk(5'b00010, 3'd1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL t3_body got=%b exp=%b", snap(), exp); end
      @(negedge clk);
      drive(1, 1'b0, 1'b1, 2'b01);
      #1;
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL t3_tail got=%b exp=%b", snap(), exp); end
      @(negedge clk);
      drive(1, 1'b0, 1'b0, 2'b00);
      #1;
      exp = mk(5'b00000, 3'd7, 1'b0, 1'b0, 1'b0);
      checks++;
      if (snap() !== exp || pkt_count !== 16'd1) begin
         failures++; $display("FAIL t3_release got=%b cnt=%0d exp=%b cnt=1", snap(), pkt_count, exp);
      end
      @(negedge clk); #1;
      exp = mk(5'b00100, 3'd2, 1'b1, 1'b1, 1'b0);
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL t3_w_grant got=%b exp=%b", snap(), exp); end
      @(negedge clk);
      clear_all();
      #1;
      exp = mk(5'b00000, 3'd7, 1'b0, 1'b0, 1'b0);
      checks++;
      if (snap() !== exp || pkt_count !== 16'd2) begin
         failures++; $display("FAIL t3_w_done got=%b cnt=%0d exp=%b cnt=2", snap(), pkt_count, exp);
      end
   endtask

   task automatic test_valid_gap();
      test_reset();
      @(negedge clk);
      drive(3, 1'b1, 1'b1, 2'b10);
      out_ready = 1'b1;
      @(negedge clk); #1;
      exp = mk(5'b01000, 3'd3, 1'b1, 1'b1, 1'b0);
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL t4_head got=%b exp=%b", snap(), exp); end
      @(negedge clk);
      drive(3, 1'b0, 1'b1, 2'b00);
      #1;
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL t4_body1 got=%b exp=%b", snap(), exp); end
      // Tail-typed but invalid flits during the gap must not release.
      exp = mk(5'b01000, 3'd3, 1'b0, 1'b1, 1'b0);
      for (int g = 0; g < 3; g++) begin
         @(negedge clk);
         drive(3, 1'b0, 1'b0, 2'b01);
         #1;
         checks++;
         if (snap() !== exp) begin failures++; $display("FAIL t4_gap%0d got=%b exp=%b", g, snap(), exp); end
      end
      @(negedge clk);
      drive(3, 1'b0, 1'b1, 2'b00);
      #1;
      exp = mk(5'b01000, 3'd3, 1'b1, 1'b1, 1'b0);
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL t4_body2 got=%b exp=%b", snap(), exp); end
      @(negedge clk);
      drive(3, 1'b0, 1'b1, 2'b01);
      #1;
      checks++;
      if (snap() !== exp || pkt_count !== 16'd0) begin
         failures++; $display("FAIL t4_tail got=%b cnt=%0d exp=%b cnt=0", snap(), pkt_count, exp);
      end
      @(negedge clk);
      clear_all();
      #1;
      exp = mk(5'b00000, 3'd7, 1'b0, 1'b0, 1'b0);
      checks++;
      if (snap() !== exp || pkt_count !== 16'd1) begin
         failures++; $display("FAIL t4_release got=%b cnt=%0d exp=%b cnt=1", snap(), pkt_count, exp);
      end
   endtask

   task automatic test_protocol_error();
      test_reset();
      @(negedge clk);
      drive(4, 1'b1, 1'b1, 2'b10);
      out_ready = 1'b1;
      @(negedge clk); #1;
      exp = mk(5'b10000, 3'd4, 1'b1, 1'b1, 1'b0);
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL t5_head got=%b exp=%b", snap(), exp); end
      @(negedge clk);
      drive(4, 1'b0, 1'b1, 2'b00);
      #1;
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL t5_body got=%b exp=%b", snap(), exp); end
      @(negedge clk);
      drive(4, 1'b0, 1'b1, 2'b10);
      #1;
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL t5_second_head got=%b exp=%b", snap(), exp); end
      @(negedge clk);
      drive(4, 1'b0, 1'b1, 2'b01);
      #1;
      exp = mk(5'b10000, 3'd4, 1'b1, 1'b1, 1'b1);
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL t5_err_set got=%b exp=%b", snap(), exp); end
      @(negedge clk);
      clear_all();
      #1;
      exp = mk(5'b00000, 3'd7, 1'b0, 1'b0, 1'b1);
      checks++;
      if (snap() !== exp || pkt_count !== 16'd1) begin
         failures++; $display("FAIL t5_release got=%b cnt=%0d exp=%b cnt=1", snap(), pkt_count, exp);
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (err !== 1'b1) begin failures++; $display("FAIL t5_err_sticky got=%b exp=1", err); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 2'b10);
      out_ready = 1'b1;
      @(negedge clk); #1;
      exp = mk(5'b00010, 3'd1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL t6_grant got=%b exp=%b", snap(), exp); end
      @(negedge clk);
      drive(1, 1'b0, 1'b1, 2'b00);
      #2;
      rst = 1'b1;
      #1;
      exp = mk(5'b00000, 3'd7, 1'b0, 1'b0, 1'b0);
      checks++;
      if (snap() !== exp || pkt_count !== 16'd0) begin
         failures++; $display("FAIL t6_async got=%b cnt=%0d exp=%b cnt=0", snap(), pkt_count, exp);
      end
      clear_all();
      @(negedge clk);
      rst = 1'b0;
      drive(0, 1'b1, 1'b1, 2'b11);
      drive(1, 1'b1, 1'b1, 2'b11);
      @(negedge clk); #1;
      exp = mk(5'b00001, 3'd0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (snap() !== exp) begin failures++; $display("FAIL t6_restart got=%b exp=%b", snap(), exp); end
      @(negedge clk);
      clear_all();
      #1;
      exp = mk(5'b00000, 3'd7, 1'b0, 1'b0, 1'b0);
      checks++;
      if (snap() !== exp || pkt_count !== 16'd1) begin
         failures++; $display("FAIL t6_done got=%b cnt=%0d exp=%b cnt=1", snap(), pkt_count, exp);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      out_ready = 1'b0;
      req       = '0;
      fv        = '0;
      ftype     = '0;
      test_reset();
      test_single_packet();
      test_round_robin();
      test_stall();
      test_valid_gap();
      test_protocol_error();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
Per-output-port wormhole arbiter for the 5-port mesh router. It collects one request bit from each input port's routing logic for this output, grants one input at a time in round-robin order, and holds the grant until the packet's tail flit has crossed the crossbar. The arbiter drives the crossbar select and output-valid for its port; one instance sits on each of the L/E/W/S/N outputs.

Parameters:
NUM_IN, 5, number of requesting input ports; index 0=L, 1=E, 2=W, 3=S, 4=N, matching routing-logic outputs e1..e5.
CNT_W, 16, width of the delivered-packet counter.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-high
req  in  NUM_IN  req[i]=1: input i's head flit is routed to this output (that input's routing-logic e-bit for this port)
flit_valid  in  NUM_IN  flit_valid[i]=1: input i presents a valid flit this cycle
flit_type  in  2*NUM_IN  flit_type[2i+1:2i] = flit[7:6] of input i; 10=head, 00=body, 01=tail, 11=head+tail (single-flit)
out_ready  in  1  downstream buffer can accept a flit this cycle
grant  out  NUM_IN  one-hot registered grant; all zero when idle
xbar_sel  out  3  binary index of the granted input; 3'd7 when idle
out_valid  out  1  flit transfers through this output this cycle
busy  out  1  1 while in LOCKED
pkt_count  out  CNT_W  number of packets whose last flit has transferred; wraps at 2^CNT_W
err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst=1): state=IDLE, grant=0, xbar_sel=7, busy=0, ptr=0 (L has top priority), pkt_count=0, err=0. out_valid=0 while grant=0. Reset mid-packet drops ownership immediately; no flit is counted.
- Eligible request: cand[i] = req[i] & flit_valid[i] & flit_type[i][1] (head or head+tail). Requests with body/tail type are ignored.
- IDLE: if any cand, choose the first set index at or after ptr, in order ptr, ptr+1, ... mod NUM_IN. At the clock edge: grant<=onehot(winner), xbar_sel<=winner, state<=LOCKED. If there is no cand, stay in IDLE. Latency is one cycle from request to grant.
- LOCKED (owner o): out_valid = flit_valid[o] & out_ready (combinational). A transfer happens when out_valid=1. If out_ready=0 or flit_valid[o]=0, hold with no transfer; there is no timeout.
- Release: a transfer whose type is 01 or 11 is the packet end. At that edge: state<=IDLE, grant<=0, xbar_sel<=7, ptr<=(o+1) mod NUM_IN, pkt_count<=pkt_count+1.
- The owner's head flit transfers in the first LOCKED cycle in which out_ready=1.
- A single-flit packet (11) gets grant for one cycle if out_ready=1 and is then released.
- At least one IDLE cycle separates consecutive packets. There is no same-edge re-grant.
- Requests from non-owners during LOCKED are ignored. They must hold req and their head flit; the arbiter keeps no memory of them.
- err<=1 when, in LOCKED, the owner presents flit_valid=1 with type 10 after its first transfer (a new head before the tail). err clears only on reset. Grant is unaffected.
- Simultaneous requests from all 5 inputs: served in order ptr..ptr+4. No input waits more than 4 packets.
- ptr wraps 4 -> 0.
- pkt_count wraps from all-ones to 0.

Test Plan:
1. Reset, then req=00001 with L flit_valid, head, tail a few cycles later (4-flit packet), out_ready=1 -> grant=00001 and xbar_sel=0 one cycle after the request; out_valid=1 for 4 cycles; after the tail edge grant=0, xbar_sel=7, pkt_count=1, ptr=1.
2. All 5 inputs requesting single-flit packets continuously from ptr=0 -> grant sequence 00001, 00010, 00100, 01000, 10000, 00001, with an IDLE cycle between each; pkt_count increments by 1 per packet.
3. E owns a 3-flit packet, out_ready=0 for 5 cycles mid-packet -> grant holds 00010, out_valid=0 during the stall, and no competing W request is granted until after E's tail.
4. Owner drops flit_valid for 3 cycles between body flits -> grant held, out_valid=0 during the gap, release only on the tail transfer.
5. Owner sends head, body, head (type 10) -> err=1 on the edge after the second head and remains 1 until rst; grant is unchanged.
6. rst asserted asynchronously mid-packet (between edges) -> grant=0, busy=0, xbar_sel=7 immediately; pkt_count=0; after rst=0 arbitration restarts with L highest priority.
